// File: rtl/tff_ctrl_pkg.sv
// Shared state encoding and direction constants for the T flip-flop counter controller.
// Pure declarations: no logic, no latency, no flow control.
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_bit.sv
// Single T flip-flop: q inverts on every rising edge where t=1.
// One-cycle latency from t to q; asynchronous active-low reset clears q.
module tff_bit (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Start/done controlled up/down terminal counter built purely from per-bit T flip-flop toggles.
// N-count run: DONE at E(N+1), IDLE at E(N+2); halt stretches RUN; optional abort via TFF_CTRL_ABORT_EN.
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
`ifdef TFF_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] count_max,
  input  logic             halt,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] toggle,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] toggle_c;
  logic [WIDTH-1:0] tog_up;
  logic [WIDTH-1:0] tog_dn;
  logic             at_term;
  logic             abort_hit;

  // Increment flips every bit below and including the lowest 0; decrement mirrors it on the 1s.
  always_comb begin
    tog_up    = '0;
    tog_dn    = '0;
    tog_up[0] = 1'b1;
    tog_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      tog_up[i] = tog_up[i-1] & count[i-1];
      tog_dn[i] = tog_dn[i-1] & ~count[i-1];
    end
  end

  always_comb begin
    at_term = (dir_q == DIR_UP) ? (count == max_q) : (count == '0);
  end

`ifdef TFF_CTRL_ABORT_EN
  always_comb begin
    abort_hit = abort && ((state_q == ST_RUN) || (state_q == ST_DONE));
  end
`else
  always_comb begin
    abort_hit = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    max_d    = max_q;
    toggle_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d    = dir;
          max_d    = count_max;
          state_d  = ST_RUN;
          // The load goes through the toggles too, so the old end value is cancelled out.
          toggle_c = (dir == DIR_DOWN) ? (count ^ count_max) : count;
        end
      end
      ST_RUN: begin
        if (at_term) begin
          state_d = ST_DONE;
        end else if (!halt) begin
          toggle_c = (dir_q == DIR_DOWN) ? tog_dn : tog_up;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort_hit) begin
      state_d  = ST_IDLE;
      toggle_c = count;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      max_q   <= max_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    tff_bit u_bit (
      .clk   (clk),
      .reset (reset),
      .t     (toggle_c[g]),
      .q     (count[g])
    );
  end

  assign toggle = toggle_c;
  assign busy   = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done   = (state_q == ST_DONE) && !abort_hit;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl: run table expanded into per-cycle expectations, plus reset/abort sequences.
module tb_tff_count_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         dir;
  logic         halt;
  logic         abort;
  logic [W-1:0] count_max;
  logic [W-1:0] count;
  logic [W-1:0] toggle;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  tff_count_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef TFF_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .dir       (dir),
    .count_max (count_max),
    .halt      (halt),
    .count     (count),
    .toggle    (toggle),
    .busy      (busy),
    .done      (done)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic         start;
    logic         halt;
    logic         abrt;
    logic         dir;
    logic [W-1:0] max;
    logic [W-1:0] c;
    logic [W-1:0] t;
    logic         b;
    logic         d;
  } cyc_t;

  typedef struct {
    logic         dir;
    logic [W-1:0] max;
    logic [W-1:0] halt_at;
    int           halt_len;
    logic         halt_term;
    logic         hold;
  } run_t;

  cyc_t         sb[$];
  logic [W-1:0] mc;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic s, input logic h, input logic a, input logic dr,
                      input logic [W-1:0] mx, input logic [W-1:0] c, input logic [W-1:0] t,
                      input logic b, input logic d);
    cyc_t r;
    r.start = s; r.halt = h; r.abrt = a; r.dir = dr; r.max = mx;
    r.c = c; r.t = t; r.b = b; r.d = d;
    sb.push_back(r);
  endtask

  // Expected per-cycle trace of one run, from the start cycle in IDLE through DONE.
  task automatic gen_run(input run_t v);
    logic [W-1:0] nxt;
    bit           halted;
    halted = 0;
    push(1'b1, 1'b0, 1'b0, v.dir, v.max, mc, v.dir ? (mc ^ v.max) : mc, 1'b0, 1'b0);
    mc = v.dir ? v.max : '0;
    for (int k = 0; k < 40; k++) begin
      if (v.dir ? (mc == '0) : (mc == v.max)) break;
      if (v.halt_len > 0 && mc == v.halt_at && !halted) begin
        for (int j = 0; j < v.halt_len; j++)
          push(v.hold, 1'b1, 1'b0, ~v.dir, ~v.max, mc, '0, 1'b1, 1'b0);
        halted = 1;
      end
      nxt = v.dir ? mc - 1'b1 : mc + 1'b1;
      push(v.hold, 1'b0, 1'b0, ~v.dir, ~v.max, mc, mc ^ nxt, 1'b1, 1'b0);
      mc = nxt;
    end
    push(v.hold, v.halt_term, 1'b0, ~v.dir, ~v.max, mc, '0, 1'b1, 1'b0);
    push(v.hold, 1'b0, 1'b0, v.dir, v.max, mc, '0, 1'b1, 1'b1);
    if (!v.hold) push(1'b0, 1'b0, 1'b0, v.dir, v.max, mc, '0, 1'b0, 1'b0);
  endtask

  task automatic play();
    cyc_t r;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(negedge clk);
      start = r.start; halt = r.halt; abort = r.abrt; dir = r.dir; count_max = r.max;
      #1;
      chk("count", count, r.c);
      chk("toggle", toggle, r.t);
      chk1("busy", busy, r.b);
      chk1("done", done, r.d);
    end
  endtask

  run_t runs[10];

  initial begin
    runs[0] = '{dir: 1'b0, max: 4'd3,  halt_at: 4'd0, halt_len: 0, halt_term: 1'b0, hold: 1'b0};
    runs[1] = '{dir: 1'b1, max: 4'd10, halt_at: 4'd0, halt_len: 0, halt_term: 1'b0, hold: 1'b0};
    runs[2] = '{dir: 1'b0, max: 4'd6,  halt_at: 4'd2, halt_len: 3, halt_term: 1'b0, hold: 1'b0};
    runs[3] = '{dir: 1'b0, max: 4'd0,  halt_at: 4'd0, halt_len: 0, halt_term: 1'b0, hold: 1'b0};
    runs[4] = '{dir: 1'b1, max: 4'd5,  halt_at: 4'd3, halt_len: 2, halt_term: 1'b1, hold: 1'b0};
    runs[5] = '{dir: 1'b0, max: 4'd15, halt_at: 4'd0, halt_len: 0, halt_term: 1'b0, hold: 1'b0};
    runs[6] = '{dir: 1'b1, max: 4'd0,  halt_at: 4'd0, halt_len: 0, halt_term: 1'b0, hold: 1'b0};
    runs[7] = '{dir: 1'b0, max: 4'd2,  halt_at: 4'd0, halt_len: 0, halt_term: 1'b0, hold: 1'b1};
    runs[8] = '{dir: 1'b1, max: 4'd4,  halt_at: 4'd0, halt_len: 0, halt_term: 1'b0, hold: 1'b1};
    runs[9] = '{dir: 1'b0, max: 4'd5,  halt_at: 4'd0, halt_len: 0, halt_term: 1'b0, hold: 1'b0};

    reset = 1'b0; start = 1'b0; halt = 1'b0; abort = 1'b0; dir = 1'b0; count_max = '0;
    #1;
    chk("rst_count", count, '0);
    chk("rst_toggle", toggle, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    mc = '0;

    for (int i = 0; i < 10; i++) gen_run(runs[i]);
    play();

    // Asynchronous reset in the middle of a run to 9, taken while count=5.
    @(negedge clk);
    start = 1'b1; dir = 1'b0; count_max = 4'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_count", count, 4'd5);
    chk1("pre_rst_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_rst_count", count, '0);
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_count", count, '0);
      chk1("post_rst_busy", busy, 1'b0);
      chk1("post_rst_done", done, 1'b0);
    end
    mc = '0;

`ifdef TFF_CTRL_ABORT_EN
    // Abort at count=4 of a run to 9; abort while idle must do nothing.
    push(1'b0, 1'b0, 1'b1, 1'b0, 4'd9, mc, '0, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, mc, mc, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] kv;
      kv = W'(k);
      push(1'b0, 1'b0, 1'b0, 1'b0, 4'd9, kv, kv ^ (kv + 1'b1), 1'b1, 1'b0);
    end
    push(1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd4, 4'd4, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, '0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, '0, 1'b0, 1'b0);
    play();
    mc = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
